// File: rtl/cpu_step_clock.sv
// CPU clock source: free-running divided clock (fast/slow) or one debounced
// pulse per step-button press, with a rise strobe and a rising-edge counter.
module cpu_step_clock #(
   parameter int DEB_CNT    = 50000,
   parameter int FAST_DIV   = 2,
   parameter int SLOW_DIV   = 24,
   parameter int PULSE_HALF = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mode_run,
   input  logic        speed_sel,
   input  logic        step_btn,
   input  logic        halt,
   output logic        cpu_clk,
   output logic        cpu_rise,
   output logic [31:0] step_cnt,
   output logic        btn_db
);

   localparam int            DW       = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
   localparam logic [31:0]   H_FAST   = 32'd1 << FAST_DIV;
   localparam logic [31:0]   H_SLOW   = 32'd1 << SLOW_DIV;
   localparam logic [31:0]   H_STEP   = 32'(PULSE_HALF);

   typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_btn_sync;
   logic [1:0]    r_run_sync;
   logic [1:0]    r_spd_sync;
   logic [DW-1:0] r_deb_cnt;
   logic          r_btn_db;
   logic          r_pending;
   logic          r_cpu_clk;
   logic          r_cpu_rise;
   logic [31:0]   r_step_cnt;
   logic [31:0]   r_phase;
   logic [31:0]   r_half;
   logic          w_btn;
   logic          w_run;
   logic          w_spd;
   logic          w_deb_fire;
   logic          w_press;
   logic          w_phase_end;
   logic          w_enter_hi;
   logic [31:0]   w_half_nxt;

   assign w_btn       = r_btn_sync[1];
   assign w_run       = r_run_sync[1];
   assign w_spd       = r_spd_sync[1];
   assign w_deb_fire  = (w_btn != r_btn_db) && (r_deb_cnt == DEB_LAST);
   assign w_press     = w_deb_fire && w_btn && !w_run;
   assign w_phase_end = (r_phase == r_half - 32'd1);
   assign w_half_nxt  = w_run ? (w_spd ? H_SLOW : H_FAST) : H_STEP;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_btn_sync <= '0;
         r_run_sync <= '0;
         r_spd_sync <= '0;
         r_deb_cnt  <= '0;
         r_btn_db   <= 1'b0;
      end else begin
         r_btn_sync <= {r_btn_sync[0], step_btn};
         r_run_sync <= {r_run_sync[0], mode_run};
         r_spd_sync <= {r_spd_sync[0], speed_sel};
         if (w_btn == r_btn_db) begin
            r_deb_cnt <= '0;
         end else if (w_deb_fire) begin
            r_btn_db  <= w_btn;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
         end
      end
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_enter_hi  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!halt && (w_run || r_pending)) begin
               w_state_nxt = S_HI;
               w_enter_hi  = 1'b1;
            end
         end
         S_HI: begin
            if (w_phase_end) w_state_nxt = S_LO;
         end
         S_LO: begin
            if (w_phase_end) begin
               if (w_run && !halt) begin
                  w_state_nxt = S_HI;
                  w_enter_hi  = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Half-period is latched at HI entry so mode/speed changes never truncate a pulse.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_pending  <= 1'b0;
         r_cpu_clk  <= 1'b0;
         r_cpu_rise <= 1'b0;
         r_step_cnt <= '0;
         r_phase    <= '0;
         r_half     <= H_STEP;
      end else begin
         r_state    <= w_state_nxt;
         r_cpu_clk  <= (w_state_nxt == S_HI);
         r_cpu_rise <= w_enter_hi;
         if (w_enter_hi) begin
            r_pending  <= 1'b0;
            r_phase    <= '0;
            r_half     <= w_half_nxt;
            r_step_cnt <= r_step_cnt + 32'd1;
         end else begin
            if (w_press && (r_state == S_IDLE)) r_pending <= 1'b1;
            if (r_state != S_IDLE) r_phase <= w_phase_end ? 32'd0 : r_phase + 32'd1;
         end
      end
   end

   assign cpu_clk  = r_cpu_clk;
   assign cpu_rise = r_cpu_rise;
   assign step_cnt = r_step_cnt;
   assign btn_db   = r_btn_db;

endmodule

// File: tb/tb_cpu_step_clock.sv
// Scoreboard bench for cpu_step_clock: scenarios push expected cpu_clk pulses,
// a negedge monitor pops and compares each one when cpu_rise appears.
module tb_cpu_step_clock;

   localparam int DEB = 4;
   localparam int HF  = 2;   // 2^FAST_DIV
   localparam int HS  = 8;   // 2^SLOW_DIV
   localparam int HP  = 2;   // PULSE_HALF

   logic        clk       = 1'b0;
   logic        rstn      = 1'b0;
   logic        mode_run  = 1'b0;
   logic        speed_sel = 1'b0;
   logic        step_btn  = 1'b0;
   logic        halt      = 1'b0;
   logic        cpu_clk;
   logic        cpu_rise;
   logic        btn_db;
   logic [31:0] step_cnt;

   typedef struct {
      int          rise;
      int          hi;
      logic [31:0] cnt;
   } pulse_t;

   pulse_t      exp_q[$];
   logic [31:0] m_cnt       = '0;
   int          cyc         = 0;
   int          n_checks    = 0;
   int          n_pass      = 0;
   int          db_rises    = 0;
   int          db_rise_cyc = -1;

   cpu_step_clock #(
      .DEB_CNT   (DEB),
      .FAST_DIV  (1),
      .SLOW_DIV  (3),
      .PULSE_HALF(HP)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .mode_run (mode_run),
      .speed_sel(speed_sel),
      .step_btn (step_btn),
      .halt     (halt),
      .cpu_clk  (cpu_clk),
      .cpu_rise (cpu_rise),
      .step_cnt (step_cnt),
      .btn_db   (btn_db)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   // Inputs change 1 ns after a falling edge; cyc then equals the number of rising edges so far.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   function automatic void expect_rise(input int rise, input int hi);
      pulse_t p;
      m_cnt  = m_cnt + 32'd1;
      p.rise = rise;
      p.hi   = hi;
      p.cnt  = m_cnt;
      exp_q.push_back(p);
   endfunction

   // Monitor: compares every observed pulse against the head of the scoreboard.
   int   hi_len   = 0;
   int   hi_exp   = 0;
   bit   in_hi    = 1'b0;
   logic prev_clk = 1'b0;
   logic prev_db  = 1'b0;

   always @(negedge clk) begin
      pulse_t p;
      if (!rstn) begin
         in_hi    = 1'b0;
         prev_clk = 1'b0;
         prev_db  = 1'b0;
      end else begin
         if (in_hi) begin
            if (!cpu_clk) begin
               check("hi_len", hi_len, hi_exp);
               in_hi = 1'b0;
            end else if (!cpu_rise) begin
               hi_len++;
            end
         end
         if (cpu_rise || (cpu_clk && !prev_clk)) begin
            check("rise_strobe", {31'd0, cpu_rise}, {31'd0, cpu_clk && !prev_clk});
            if (cpu_rise) begin
               check("rise_expected", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  p = exp_q.pop_front();
                  check("rise_cycle", cyc, p.rise);
                  check("rise_step_cnt", step_cnt, p.cnt);
                  hi_exp = p.hi;
                  hi_len = 1;
                  in_hi  = 1'b1;
               end
            end
         end
         if (btn_db && !prev_db) begin
            db_rises++;
            db_rise_cyc = cyc;
         end
         prev_clk = cpu_clk;
         prev_db  = btn_db;
      end
   end

   initial begin
      int c, r1, b, h, db0;

      // Reset, then 50 quiet cycles in step mode with no button.
      tick(3);
      check("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      check("rst_cpu_rise", {31'd0, cpu_rise}, 32'd0);
      check("rst_step_cnt", step_cnt, 32'd0);
      check("rst_btn_db", {31'd0, btn_db}, 32'd0);
      rstn = 1'b1;
      tick(50);
      check("quiet_step_cnt", step_cnt, 32'd0);
      check("quiet_btn_db", {31'd0, btn_db}, 32'd0);
      check("quiet_cpu_clk", {31'd0, cpu_clk}, 32'd0);

      // Free-run fast: first rise on the 3rd edge, then period 2*HF, 20 pulses.
      tick($urandom_range(1, 5));
      c = cyc;
      mode_run = 1'b1;
      for (int k = 0; k < 20; k++) expect_rise(c + 3 + 2 * HF * k, HF);
      wait_cyc(c + 3 + 2 * HF * 19);
      mode_run = 1'b0;
      tick(12);
      check("run_step_cnt", step_cnt, 32'd20);
      check("run_drained", exp_q.size(), 32'd0);

      // Speed flip during the first HI: that period stays fast, the next ones are slow.
      tick($urandom_range(1, 5));
      c  = cyc;
      r1 = c + 3;
      mode_run = 1'b1;
      expect_rise(r1, HF);
      expect_rise(r1 + 2 * HF, HS);
      expect_rise(r1 + 2 * HF + 2 * HS, HS);
      wait_cyc(r1);
      speed_sel = 1'b1;
      wait_cyc(r1 + 2 * HF + 2 * HS);
      mode_run = 1'b0;
      tick(2 * HS + 6);
      speed_sel = 1'b0;
      check("speed_step_cnt", step_cnt, m_cnt);
      check("speed_drained", exp_q.size(), 32'd0);

      // Step mode: bounce 1,0,1,0 with short random segments, then a clean hold.
      tick($urandom_range(2, 6));
      db0 = db_rises;
      for (int i = 0; i < 2; i++) begin
         step_btn = 1'b1;
         tick($urandom_range(1, 3));
         step_btn = 1'b0;
         tick($urandom_range(1, 3));
      end
      b = cyc;
      step_btn = 1'b1;
      expect_rise(b + 3 + DEB, HP);
      tick(10);
      step_btn = 1'b0;
      tick(20);
      check("step_db_rises", db_rises - db0, 32'd1);
      check("step_db_rise_cyc", db_rise_cyc, b + 2 + DEB);
      check("step_btn_db_low", {31'd0, btn_db}, 32'd0);
      check("step_step_cnt", step_cnt, m_cnt);
      check("step_drained", exp_q.size(), 32'd0);

      // Halt holds a pending step; a second press while pending is dropped.
      halt = 1'b1;
      tick(2);
      step_btn = 1'b1;
      tick(8);
      step_btn = 1'b0;
      tick(12);
      check("halt_blocks_step", step_cnt, m_cnt);
      step_btn = 1'b1;
      tick(8);
      step_btn = 1'b0;
      tick(12);
      check("halt_db_rises", db_rises - db0, 32'd3);
      check("halt_still_blocked", step_cnt, m_cnt);
      h = cyc;
      halt = 1'b0;
      expect_rise(h + 1, HP);
      tick(20);
      check("pending_step_cnt", step_cnt, m_cnt);
      check("pending_drained", exp_q.size(), 32'd0);

      // Free-run halted on the first HI cycle: pulse completes, then IDLE until release.
      tick($urandom_range(1, 5));
      c  = cyc;
      r1 = c + 3;
      mode_run = 1'b1;
      expect_rise(r1, HF);
      wait_cyc(r1);
      halt = 1'b1;
      tick(4 + $urandom_range(2, 8));
      check("halted_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      check("halted_step_cnt", step_cnt, m_cnt);
      h = cyc;
      halt = 1'b0;
      expect_rise(h + 1, HF);
      wait_cyc(h + 1);
      mode_run = 1'b0;
      tick(10);
      check("restart_step_cnt", step_cnt, m_cnt);
      check("restart_drained", exp_q.size(), 32'd0);

      // Counter wrap via a forced 0xFFFFFFFF, then reset in the middle of HI.
      tick(3);
      force dut.r_step_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.r_step_cnt;
      m_cnt = 32'hFFFF_FFFF;
      c  = cyc;
      r1 = c + 3;
      mode_run = 1'b1;
      expect_rise(r1, HF);
      wait_cyc(r1);
      rstn     = 1'b0;
      mode_run = 1'b0;
      tick();
      check("midhi_rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      check("midhi_rst_cpu_rise", {31'd0, cpu_rise}, 32'd0);
      check("midhi_rst_step_cnt", step_cnt, 32'd0);
      check("midhi_rst_btn_db", {31'd0, btn_db}, 32'd0);
      tick(2);
      rstn = 1'b1;
      tick(10);
      check("post_rst_step_cnt", step_cnt, 32'd0);
      check("post_rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
      check("final_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
